// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader: opcode encodings
// and the loader state encoding. The CHECK state exists only when the
// PROG_LOADER_CHECKSUM_EN macro is defined.
package prog_loader_pkg;

  // Opcode occupies the top bit of every instruction word.
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_ADD  = 1'b1;

  // A NOP is "LOAD 0": opcode LOAD with all data bits zero, i.e. an all-zero word.
  localparam logic NOP_FILL_BIT = OP_LOAD;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_CHECK,
    S_RUN,
    S_ERROR
  } loader_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RUN,
    S_ERROR
  } loader_state_t;
`endif

endpackage

// File: rtl/prog_loader.sv
// Writer side of the CPU instruction memory. Accepts a program as a
// valid/ready word stream, writes it into imem from address 0, pads the
// remaining slots with NOPs and then releases the CPU from reset.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN -- a trailing checksum
// word (sum of all program words mod 2**INSN_W) must match before RUN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int INSN_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_data,
  output logic              cpu_reset,
  output logic              err
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W + 1)'(1);
  localparam logic [INSN_W-1:0] NOP_WORD = {INSN_W{NOP_FILL_BIT}};

  loader_state_t   state;
  // One extra bit so the pointer can step past the last slot without
  // aliasing back to address 0.
  logic [ADDR_W:0] wptr;
  logic            accept;
  logic            at_last;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSN_W-1:0] csum;
`endif

  assign accept  = in_valid & in_ready;
  assign at_last = (wptr == LAST_PTR);

  // Loader FSM with all outputs registered.
  // NOTE: state and outputs use non-blocking assignments so every branch reads
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wptr      <= '0;
      in_ready  <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
      cpu_reset <= 1'b1;
      err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless a branch below re-arms it.
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state     <= S_LOAD;
            wptr      <= '0;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end else if (state == S_RUN) begin
            // Release lands one cycle after the final imem write.
            cpu_reset <= 1'b0;
          end
        end

        S_LOAD: begin
          if (accept) begin
            imem_we   <= 1'b1;
            imem_addr <= wptr[ADDR_W-1:0];
            imem_data <= in_data;
            wptr      <= wptr + PTR_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= csum + in_data;
`endif
            if (in_last && !at_last) begin
              state    <= S_FILL;
              in_ready <= 1'b0;
            end else if (in_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state    <= S_CHECK;
`else
              state    <= S_RUN;
              in_ready <= 1'b0;
`endif
            end else if (at_last) begin
              // Program longer than imem: the word is still written, then stop.
              state    <= S_ERROR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end
          end
        end

        S_FILL: begin
          imem_we   <= 1'b1;
          imem_addr <= wptr[ADDR_W-1:0];
          imem_data <= NOP_WORD;
          wptr      <= wptr + PTR_ONE;
          if (at_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state    <= S_CHECK;
            in_ready <= 1'b1;
`else
            state    <= S_RUN;
`endif
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          // The checksum word is compared only, never written to imem.
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state <= S_RUN;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Default build runs a cycle-by-cycle
// vector table; with PROG_LOADER_CHECKSUM_EN the checksum sequences run instead.
// Mid-load reset is checked in both builds.
`timescale 1ns/1ps
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       in_last;
  logic       imem_we;
  logic [1:0] imem_addr;
  logic [1:0] imem_data;
  logic       cpu_reset;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [1:0] mem [4];

  prog_loader #(.ADDR_W(2), .INSN_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_reset (cpu_reset),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Shadow of imem built from the observed write port.
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_data;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are sampled at the next one.
  task automatic drive(input logic st, input logic v, input logic [1:0] d, input logic l);
    start    = st;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic check_mem(input string tag, input logic [1:0] m0, input logic [1:0] m1,
                           input logic [1:0] m2, input logic [1:0] m3);
    check({tag, "_m0"}, 8'(mem[0]), 8'(m0));
    check({tag, "_m1"}, 8'(mem[1]), 8'(m1));
    check({tag, "_m2"}, 8'(mem[2]), 8'(m2));
    check({tag, "_m3"}, 8'(mem[3]), 8'(m3));
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  // Bounded wait for in_ready; an expired budget shows up as a failed comparison.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 20) begin
      drive(1'b0, 1'b0, 2'd0, 1'b0);
      n++;
    end
    check(name, 8'(in_ready), 8'd1);
  endtask
`else
  typedef struct {
    logic       start;
    logic       valid;
    logic [1:0] data;
    logic       last;
    logic       rdy;
    logic       we;
    logic [1:0] addr;
    logic [1:0] wdata;
    logic       cr;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int st, int v, int d, int l, int rdy, int we, int a, int wd,
                              int cr, int er);
    vec_t x;
    x.start = 1'(st);
    x.valid = 1'(v);
    x.data  = 2'(d);
    x.last  = 1'(l);
    x.rdy   = 1'(rdy);
    x.we    = 1'(we);
    x.addr  = 2'(a);
    x.wdata = 2'(wd);
    x.cr    = 1'(cr);
    x.er    = 1'(er);
    vecs.push_back(x);
  endfunction
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 2'd0;
    reset = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_data = 2'd0; in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 8'(in_ready), 8'd0);
    check("rst_we",    8'(imem_we),  8'd0);
    check("rst_addr",  8'(imem_addr), 8'd0);
    check("rst_data",  8'(imem_data), 8'd0);
    check("rst_cpu",   8'(cpu_reset), 8'd1);
    check("rst_err",   8'(err),      8'd0);
    reset = 1'b0;
    @(negedge clk);

`ifndef PROG_LOADER_CHECKSUM_EN
    // Columns: start valid data last | ready we addr wdata cpu_reset err
    // Test 1: short program, padded with two NOPs, then RUN.
    add(1,0,0,0, 1,0,0,0,1,0);
    add(0,1,1,0, 1,1,0,1,1,0);
    add(0,1,3,1, 0,1,1,3,1,0);
    add(0,0,0,0, 0,1,2,0,1,0);
    add(0,0,0,0, 0,1,3,0,1,0);
    add(0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0,0);
    // Test 2: full-depth program, last on slot 3, no fill.
    add(1,0,0,0, 1,0,0,0,1,0);
    add(0,1,1,0, 1,1,0,1,1,0);
    add(0,1,3,0, 1,1,1,3,1,0);
    add(0,1,0,0, 1,1,2,0,1,0);
    add(0,1,2,1, 0,1,3,2,1,0);
    add(0,0,0,0, 0,0,0,0,0,0);
    // Test 3: overflow -- slot 3 written without last, then ERROR until start.
    add(1,0,0,0, 1,0,0,0,1,0);
    add(0,1,2,0, 1,1,0,2,1,0);
    add(0,1,1,0, 1,1,1,1,1,0);
    add(0,1,3,0, 1,1,2,3,1,0);
    add(0,1,0,0, 0,1,3,0,1,1);
    add(0,0,0,0, 0,0,0,0,1,1);
    add(0,1,1,0, 0,0,0,0,1,1);
    add(1,0,0,0, 1,0,0,0,1,0);
    // Test 6: valid gaps, start during LOAD ignored.
    add(0,1,2,0, 1,1,0,2,1,0);
    add(1,0,0,0, 1,0,0,0,1,0);
    add(0,0,0,0, 1,0,0,0,1,0);
    add(0,1,1,1, 0,1,1,1,1,0);
    add(0,0,0,0, 0,1,2,0,1,0);
    add(0,0,0,0, 0,1,3,0,1,0);
    add(0,0,0,0, 0,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].valid, vecs[i].data, vecs[i].last);
      check($sformatf("v%0d_ready", i), 8'(in_ready),  8'(vecs[i].rdy));
      check($sformatf("v%0d_we", i),    8'(imem_we),   8'(vecs[i].we));
      check($sformatf("v%0d_cpu", i),   8'(cpu_reset), 8'(vecs[i].cr));
      check($sformatf("v%0d_err", i),   8'(err),       8'(vecs[i].er));
      if (vecs[i].we) begin
        check($sformatf("v%0d_addr", i), 8'(imem_addr), 8'(vecs[i].addr));
        check($sformatf("v%0d_data", i), 8'(imem_data), 8'(vecs[i].wdata));
      end
    end
    check_mem("t6", 2'd2, 2'd1, 2'd0, 2'd0);
`else
    // Test 4a: 01 + 11 = 00 (mod 4); matching checksum reaches RUN.
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b1);
    check("cs_fill_ready", 8'(in_ready), 8'd0);
    wait_ready("cs_check_ready");
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    check("cs_ok_ready", 8'(in_ready),  8'd0);
    check("cs_ok_we",    8'(imem_we),   8'd0);
    check("cs_ok_cpu0",  8'(cpu_reset), 8'd1);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    check("cs_ok_cpu1",  8'(cpu_reset), 8'd0);
    check("cs_ok_err",   8'(err),       8'd0);
    check_mem("cs_ok", 2'd1, 2'd3, 2'd0, 2'd0);
    // Test 4b: wrong checksum 01 -> ERROR.
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    check("cs_bad_start_cpu", 8'(cpu_reset), 8'd1);
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b1);
    wait_ready("cs_bad_check_ready");
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    check("cs_bad_err",   8'(err),       8'd1);
    check("cs_bad_cpu",   8'(cpu_reset), 8'd1);
    check("cs_bad_ready", 8'(in_ready),  8'd0);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    check("cs_bad_err_hold", 8'(err), 8'd1);
    check_mem("cs_bad", 2'd1, 2'd3, 2'd0, 2'd0);
`endif

    // Test 5: reset right after the second handshake aborts the load.
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b0);
    check("t5_we_before", 8'(imem_we), 8'd1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    check("t5_ready", 8'(in_ready),  8'd0);
    check("t5_we",    8'(imem_we),   8'd0);
    check("t5_cpu",   8'(cpu_reset), 8'd1);
    check("t5_err",   8'(err),       8'd0);
    check("t5_addr",  8'(imem_addr), 8'd0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    check("t5_idle_ready", 8'(in_ready), 8'd0);
    check("t5_idle_we",    8'(imem_we),  8'd0);
    drive(1'b0, 1'b0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
